// File: rtl/nibble_pkg.sv
// Shared definitions for the nibble packer: state encoding and the nibble-pair
// byte assembly helper.
package nibble_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HALF = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  // Places the first nibble of a pair in the low half when lsn_first is set,
  // otherwise in the high half.
  function automatic logic [7:0] pack_nibbles(input logic [3:0] first_nib,
                                              input logic [3:0] second_nib,
                                              input logic       lsn_first);
    return lsn_first ? {second_nib, first_nib} : {first_nib, second_nib};
  endfunction

endpackage

// File: rtl/nibble_packer.sv
// Packs a valid/ready stream of nibbles into bytes; odd-length packets are
// padded with a zero nibble and flagged on byte_odd.
module nibble_packer
  import nibble_pkg::*;
#(
  parameter bit LSN_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] nib_in,
  input  logic       nib_valid,
  input  logic       nib_last,
  output logic       nib_ready,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       byte_last,
  output logic       byte_odd,
  input  logic       byte_ready,
  output logic [7:0] byte_count
);

  state_t     state_reg, state_next;
  logic [3:0] nib_store_reg, nib_store_next;
  logic [7:0] byte_reg, byte_next;
  logic       last_reg, last_next;
  logic       odd_reg, odd_next;
  logic [7:0] count_reg;
  logic       nib_hs;
  logic       byte_hs;

  assign nib_ready = (state_reg != ST_FULL) | byte_ready;
  assign nib_hs    = nib_valid & nib_ready;
  assign byte_hs   = (state_reg == ST_FULL) & byte_ready;

  always_comb begin
    state_next     = state_reg;
    nib_store_next = nib_store_reg;
    byte_next      = byte_reg;
    last_next      = last_reg;
    odd_next       = odd_reg;
    case (state_reg)
      ST_IDLE, ST_FULL: begin
        // A draining FULL behaves like IDLE in the same cycle, so a new
        // nibble can be taken without a bubble.
        if (state_reg == ST_FULL && !byte_hs) begin
          state_next = ST_FULL;
        end else if (nib_hs) begin
          if (nib_last) begin
            state_next = ST_FULL;
            byte_next  = pack_nibbles(nib_in, 4'h0, LSN_FIRST);
            last_next  = 1'b1;
            odd_next   = 1'b1;
          end else begin
            state_next     = ST_HALF;
            nib_store_next = nib_in;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_HALF: begin
        if (nib_hs) begin
          state_next = ST_FULL;
          byte_next  = pack_nibbles(nib_store_reg, nib_in, LSN_FIRST);
          last_next  = nib_last;
          odd_next   = 1'b0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      nib_store_reg <= 4'h0;
      byte_reg      <= 8'h00;
      last_reg      <= 1'b0;
      odd_reg       <= 1'b0;
      count_reg     <= 8'h00;
    end else begin
      state_reg     <= state_next;
      nib_store_reg <= nib_store_next;
      byte_reg      <= byte_next;
      last_reg      <= last_next;
      odd_reg       <= odd_next;
      if (byte_hs) begin
        count_reg <= count_reg + 8'd1;
      end
    end
  end

  assign byte_valid = (state_reg == ST_FULL);
  assign byte_out   = byte_reg;
  assign byte_last  = last_reg;
  assign byte_odd   = odd_reg;
  assign byte_count = count_reg;

endmodule

// File: tb/tb_nibble_packer.sv
// Scoreboard bench for nibble_packer: one instance per LSN_FIRST setting,
// expected bytes queued at stimulus time and checked by per-instance monitors.
module tb_nibble_packer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic [3:0] nib_in = '0, nib_in0 = '0;
  logic       nib_valid = 1'b0, nib_valid0 = 1'b0;
  logic       nib_last = 1'b0, nib_last0 = 1'b0;
  logic       byte_ready = 1'b1, byte_ready0 = 1'b1;
  logic       nib_ready, nib_ready0;
  logic [7:0] byte_out, byte_out0;
  logic       byte_valid, byte_valid0;
  logic       byte_last, byte_last0;
  logic       byte_odd, byte_odd0;
  logic [7:0] byte_count, byte_count0;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;
  int hs_cnt0  = 0;
  int stalls   = 0;

  logic [9:0] exp_q[$];
  logic [9:0] exp0_q[$];

  always #5 clk = ~clk;

  nibble_packer #(.LSN_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .nib_in(nib_in), .nib_valid(nib_valid),
    .nib_last(nib_last), .nib_ready(nib_ready), .byte_out(byte_out),
    .byte_valid(byte_valid), .byte_last(byte_last), .byte_odd(byte_odd),
    .byte_ready(byte_ready), .byte_count(byte_count)
  );

  nibble_packer #(.LSN_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .nib_in(nib_in0), .nib_valid(nib_valid0),
    .nib_last(nib_last0), .nib_ready(nib_ready0), .byte_out(byte_out0),
    .byte_valid(byte_valid0), .byte_last(byte_last0), .byte_odd(byte_odd0),
    .byte_ready(byte_ready0), .byte_count(byte_count0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitors: a byte handshake is seen at the negedge before the edge that takes it.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && byte_valid && byte_ready) begin
        hs_cnt++;
        $display("lsn1 byte %h last %b odd %b", byte_out, byte_last, byte_odd);
        if (exp_q.size() == 0) begin
          check("lsn1_unexpected_byte", {22'd0, byte_out, byte_last, byte_odd}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("lsn1_byte", {22'd0, byte_out, byte_last, byte_odd}, {22'd0, e});
        end
      end
    end
  end

  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && byte_valid0 && byte_ready0) begin
        hs_cnt0++;
        $display("lsn0 byte %h last %b odd %b", byte_out0, byte_last0, byte_odd0);
        if (exp0_q.size() == 0) begin
          check("lsn0_unexpected_byte", {22'd0, byte_out0, byte_last0, byte_odd0}, 32'hFFFF_FFFF);
        end else begin
          e = exp0_q.pop_front();
          check("lsn0_byte", {22'd0, byte_out0, byte_last0, byte_odd0}, {22'd0, e});
        end
      end
    end
  end

  // Presents one nibble and returns #1 after the edge that accepts it.
  task automatic send(input int which, input logic [3:0] n, input logic l);
    int waited;
    logic rdy;
    waited = 0;
    if (which == 0) begin
      nib_in0 = n; nib_last0 = l; nib_valid0 = 1'b1;
    end else begin
      nib_in = n; nib_last = l; nib_valid = 1'b1;
    end
    forever begin
      @(negedge clk);
      rdy = (which == 0) ? nib_ready0 : nib_ready;
      if (rdy) break;
      stalls++;
      waited++;
      if (waited > 100) begin
        $display("FAIL send_timeout: nib_ready stuck low after %0d cycles", waited);
        $fatal(1, "send timeout");
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    nib_valid = 1'b0;
    nib_valid0 = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_nib_ready", {31'd0, nib_ready}, 32'd1);
    check("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
    check("rst_outputs", {22'd0, byte_out, byte_last, byte_odd}, 32'd0);
    check("rst_byte_count", {24'd0, byte_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_nib_ready", {31'd0, nib_ready}, 32'd1);
  endtask

  initial begin
    int start_hs;
    int t;
    logic [3:0] a, b;

    do_reset();

    // 5 then A (last), low nibble first -> A5
    exp_q.push_back({8'hA5, 1'b1, 1'b0});
    send(1, 4'h5, 1'b0);
    send(1, 4'hA, 1'b1);
    nib_valid = 1'b0;
    check("latency_valid", {31'd0, byte_valid}, 32'd1);
    idle(3);
    check("count_after_a5", {24'd0, byte_count}, 32'd1);

    // Single nibble packet -> padded 07
    exp_q.push_back({8'h07, 1'b1, 1'b1});
    send(1, 4'h7, 1'b1);
    idle(3);
    check("hold_valid_low", {31'd0, byte_valid}, 32'd0);
    check("hold_outputs", {22'd0, byte_out, byte_last, byte_odd}, {22'd0, 8'h07, 1'b1, 1'b1});
    check("count_after_07", {24'd0, byte_count}, 32'd2);

    // Back-pressure on 3C with a waiting nibble, then simultaneous handshakes
    byte_ready = 1'b0;
    exp_q.push_back({8'h3C, 1'b1, 1'b0});
    send(1, 4'hC, 1'b0);
    send(1, 4'h3, 1'b1);
    exp_q.push_back({8'h09, 1'b1, 1'b1});
    nib_in = 4'h9; nib_last = 1'b1; nib_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_byte_out", {24'd0, byte_out}, 32'h3C);
      check("stall_nib_ready", {31'd0, nib_ready}, 32'd0);
      check("stall_count", {24'd0, byte_count}, 32'd2);
    end
    @(posedge clk);
    #1;
    byte_ready = 1'b1;
    @(posedge clk);
    #1;
    nib_valid = 1'b0;
    check("no_bubble_valid", {31'd0, byte_valid}, 32'd1);
    idle(3);
    check("count_after_stall", {24'd0, byte_count}, 32'd4);

    // Reset while holding F in HALF; F must not reappear
    send(1, 4'hF, 1'b0);
    nib_valid = 1'b0;
    do_reset();
    exp_q.push_back({8'h21, 1'b1, 1'b0});
    send(1, 4'h1, 1'b0);
    send(1, 4'h2, 1'b1);
    idle(3);
    check("count_after_21", {24'd0, byte_count}, 32'd1);

    // 512 back-to-back nibbles from a clean reset: 256 bytes, count wraps to 0
    do_reset();
    start_hs = hs_cnt;
    stalls = 0;
    for (int j = 0; j < 256; j++) begin
      a = 4'(2 * j);
      b = 4'(2 * j + 1);
      exp_q.push_back({b, a, (j == 255), 1'b0});
    end
    for (int k = 0; k < 512; k++) begin
      send(1, 4'(k), (k == 511));
    end
    idle(3);
    check("stream_stalls", stalls, 32'd0);
    check("stream_bytes", hs_cnt - start_hs, 32'd256);
    check("stream_count_wrap", {24'd0, byte_count}, 32'd0);

    // High nibble first instance: 5 then A -> 5A
    exp0_q.push_back({8'h5A, 1'b1, 1'b0});
    send(0, 4'h5, 1'b0);
    send(0, 4'hA, 1'b1);
    idle(3);
    check("lsn0_count", {24'd0, byte_count0}, 32'd1);

    t = 0;
    while ((exp_q.size() != 0 || exp0_q.size() != 0) && t < 50) begin
      @(posedge clk);
      t++;
    end
    check("lsn1_queue_drained", exp_q.size(), 32'd0);
    check("lsn0_queue_drained", exp0_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nibble_packer.md
NIBBLE_PACKER -- requirements
Module: nibble_packer

Interface
REQ-001 Parameter LSN_FIRST, default 1: 1 = first nibble of a pair becomes byte bits [3:0]; 0 = first nibble becomes bits [7:4].
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 nib_in  input  4  nibble data.
REQ-005 nib_valid  input  1  nib_in valid.
REQ-006 nib_last  input  1  nib_in is last nibble of a packet; qualified by nib_valid.
REQ-007 nib_ready  output  1  packer accepts nibble this cycle.
REQ-008 byte_out  output  8  assembled byte.
REQ-009 byte_valid  output  1  byte_out valid.
REQ-010 byte_last  output  1  byte_out closes a packet.
REQ-011 byte_odd  output  1  byte_out padded: only one real nibble, other nibble 4'h0.
REQ-012 byte_ready  input  1  downstream accepts byte this cycle.
REQ-013 byte_count  output  8  bytes delivered since reset, modulo 256.

Function
REQ-014 Nibble handshake = nib_valid & nib_ready on a rising edge; byte handshake = byte_valid & byte_ready on a rising edge.
REQ-015 States: IDLE (nothing held), HALF (first nibble held), FULL (byte held in output register); encoding 2 bits.
REQ-016 byte_valid SHALL be 1 exactly when state is FULL.
REQ-017 nib_ready = (state != FULL) | byte_ready; combinational, no dependency on nib_valid.
REQ-018 IDLE + nibble handshake with nib_last=0 -> HALF, nibble stored.
REQ-019 IDLE + nibble handshake with nib_last=1 -> FULL, byte = nibble in first-nibble position, other nibble 0, byte_odd=1, byte_last=1.
REQ-020 HALF + nibble handshake -> FULL, byte = {stored, new} per LSN_FIRST (LSN_FIRST=1: {new, stored}), byte_odd=0, byte_last=nib_last.
REQ-021 HALF without handshake -> stays HALF, stored nibble unchanged indefinitely.
REQ-022 FULL without byte handshake -> stays FULL; byte_out, byte_last, byte_odd held stable.
REQ-023 FULL + byte handshake, no nibble handshake -> IDLE.
REQ-024 FULL + byte handshake + simultaneous nibble handshake -> follow REQ-018/REQ-019 as from IDLE in the same cycle (no bubble).
REQ-025 Latency: byte_valid asserts the cycle after the completing nibble handshake.
REQ-026 byte_count increments by 1 on every byte handshake; 255 wraps to 0.
REQ-027 Outputs byte_out, byte_last, byte_odd are don't-care-free: held at last value (0 after reset) when byte_valid=0.
REQ-028 nib_in/nib_last ignored when nib_valid=0 or nib_ready=0.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, byte_valid 0, byte_out 8'h00, byte_last 0, byte_odd 0, byte_count 8'h00, stored nibble 4'h0.
REQ-030 Reset mid-packet (HALF or FULL) discards held data; no partial byte emitted after release.
REQ-031 nib_ready SHALL be 1 during and immediately after reset.

Structure
REQ-032 State encoding constants (IDLE=2'd0, HALF=2'd1, FULL=2'd2) in shared package nibble_pkg; 2'd3 illegal, recovers to IDLE.
REQ-033 Single module, no sub-modules; one sequential process plus combinational next-state/ready logic.

Verification
REQ-034 LSN_FIRST=1, byte_ready=1: nibbles 4'h5, 4'hA (last on 2nd) -> one byte 8'hA5, byte_last=1, byte_odd=0, byte_count=1.
REQ-035 LSN_FIRST=0: nibbles 4'h5, 4'hA -> byte 8'h5A.
REQ-036 LSN_FIRST=1: single nibble 4'h7 with nib_last=1 -> byte 8'h07, byte_odd=1, byte_last=1.
REQ-037 byte_ready=0 for 5 cycles with byte 8'h3C held: byte_out stable, nib_ready=0, no byte_count change; release -> single handshake, count +1.
REQ-038 Back-to-back stream of 512 nibbles, byte_ready=1, nib_valid=1 -> 256 bytes, one byte per 2 cycles, no stalls, byte_count wraps to 0.
REQ-039 Assert rst_n=0 in HALF after nibble 4'hF, release, send 4'h1,4'h2 -> first byte 8'h21, no trace of 4'hF.
